// File: rtl/tmac_uni_param.sv
// Unary/temporal-coded LANES-wide dot-product MAC over a 2^WIDTH-cycle stream window, binary + unary outputs.
// Latency: done 2^WIDTH+L+1 cycles after start (max(Amax,1)+L+1 with TMAC_EARLY_TERM_EN); start ignored while busy.
module tmac_uni_param #(
    parameter int WIDTH = 8,
    parameter int LANES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               scale_en,
    input  logic [LANES*WIDTH-1:0] iA,
    input  logic [LANES*WIDTH-1:0] iB,
    input  logic [WIDTH-1:0]   rng_b,
    input  logic [WIDTH-1:0]   rng_c,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               result_valid,
    output logic               sat,
    output logic               oC
);
    localparam int L   = $clog2(LANES);
    localparam int SW  = WIDTH + L;
    localparam int TCW = $clog2(L + 1);
    localparam logic [SW-1:0] MAXV = SW'((1 << WIDTH) - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_TREE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q   [LANES];
    logic [WIDTH-1:0] b_q   [LANES];
    logic [WIDTH-1:0] cnt_q [LANES];
    logic [WIDTH-1:0] t_q;
    logic [WIDTH-1:0] last_t;
    logic [TCW-1:0]   tc_q;
    logic             scale_q;
    logic [SW-1:0]    sum_q  [1:LANES-1];
    logic [SW-1:0]    node_d [2:2*LANES-1];
    logic             accept, run_last, tree_last;
    logic [SW-1:0]    root;

    assign accept    = (state_q == ST_IDLE) && start;
    assign run_last  = (state_q == ST_RUN) && (t_q == last_t);
    assign tree_last = (state_q == ST_TREE) && (tc_q == TCW'(L));
    assign root      = sum_q[1];
    assign busy      = (state_q != ST_IDLE);
    assign oC        = result_valid && (result > rng_c);

`ifdef TMAC_EARLY_TERM_EN
    // No lane can produce a 1 once t >= max(A), so the window stops there.
    logic [WIDTH-1:0] amax_d, amax_q;

    always_comb begin
        amax_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (iA[i*WIDTH +: WIDTH] > amax_d) amax_d = iA[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      amax_q <= '0;
        else if (accept) amax_q <= amax_d;
    end

    assign last_t = (amax_q == '0) ? '0 : amax_q - WIDTH'(1);
`else
    assign last_t = '1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_RUN;
            ST_RUN:  if (run_last)  state_d = ST_TREE;
            ST_TREE: if (tree_last) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                cnt_q[i] <= '0;
            end
            t_q          <= '0;
            tc_q         <= '0;
            scale_q      <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            sat          <= 1'b0;
        end else begin
            done <= tree_last;
            if (accept) begin
                for (int i = 0; i < LANES; i++) begin
                    a_q[i]   <= iA[i*WIDTH +: WIDTH];
                    b_q[i]   <= iB[i*WIDTH +: WIDTH];
                    cnt_q[i] <= '0;
                end
                scale_q      <= scale_en;
                t_q          <= '0;
                tc_q         <= '0;
                result_valid <= 1'b0;
                sat          <= 1'b0;
            end
            if (state_q == ST_RUN) begin
                t_q <= t_q + WIDTH'(1);
                for (int i = 0; i < LANES; i++) begin
                    cnt_q[i] <= cnt_q[i] +
                        WIDTH'((t_q < a_q[i]) && (rng_b < b_q[i]));
                end
            end
            if (state_q == ST_TREE) tc_q <= tc_q + TCW'(1);
            if (tree_last) begin
                result_valid <= 1'b1;
                if (scale_q) begin
                    result <= root[SW-1:L];
                    sat    <= 1'b0;
                end else if (root > MAXV) begin
                    result <= '1;
                    sat    <= 1'b1;
                end else begin
                    result <= root[WIDTH-1:0];
                    sat    <= 1'b0;
                end
            end
        end
    end

    // Heap-indexed adder tree: node k sums children 2k and 2k+1; leaves are the lane counters.
    always_comb begin
        for (int k = 2; k < LANES; k++) node_d[k] = sum_q[k];
        for (int k = LANES; k < 2*LANES; k++) node_d[k] = SW'(cnt_q[k-LANES]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < LANES; k++) sum_q[k] <= '0;
        end else begin
            for (int k = 1; k < LANES; k++) sum_q[k] <= node_d[2*k] + node_d[2*k+1];
        end
    end
endmodule

// File: tb/tb_tmac_uni_param.sv
// Scoreboard bench for tmac_uni_param: directed windows push expected results, a done-monitor checks them.
module tb_tmac_uni_param;
    localparam int W = 8;
    localparam int N = 16;
    localparam int L = 4;

    logic           clk = 1'b0;
    logic           rst_n, start, scale_en;
    logic [N*W-1:0] iA, iB;
    logic [W-1:0]   rng_b, rng_c;
    logic           busy, done, result_valid, sat, oC;
    logic [W-1:0]   result;

    tmac_uni_param #(.WIDTH(W), .LANES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scale_en(scale_en),
        .iA(iA), .iB(iB), .rng_b(rng_b), .rng_c(rng_c),
        .busy(busy), .done(done), .result(result), .result_valid(result_valid),
        .sat(sat), .oC(oC)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         sat;
        int           acc;
        int           lat;
        string        name;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    bit           rand_b_en = 1'b0;
    logic [W-1:0] a_v [N];
    logic [W-1:0] b_v [N];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic int exp_lat(input int amax);
`ifdef TMAC_EARLY_TERM_EN
        return ((amax < 1) ? 1 : amax) + L + 1;
`else
        return (1 << W) + L + 1;
`endif
    endfunction

    initial forever begin
        @(negedge clk);
        rng_b = rand_b_en ? W'($urandom) : '0;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done at cycle %0d with nothing outstanding", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_result"}, int'(result), int'(e.res));
                    chk({e.name, "_sat"}, int'(sat), int'(e.sat));
                    chk({e.name, "_valid"}, int'(result_valid), 1);
                    chk({e.name, "_busy"}, int'(busy), 0);
                    chk({e.name, "_latency"}, cyc - e.acc, e.lat);
                end
            end
        end
    end

    task automatic launch(input bit sc, input logic [W-1:0] res, input logic s,
                          input int amax, input string nm, input bit expect_done);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            iA[i*W +: W] = a_v[i];
            iB[i*W +: W] = b_v[i];
        end
        scale_en = sc;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (expect_done) begin
            e.res = res; e.sat = s; e.acc = cyc; e.lat = exp_lat(amax); e.name = nm;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; scale_en = 1'b0;
        iA = '0; iB = '0; rng_c = '1;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_oc", int'(oC), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // all A=16, B=255, rng_b=0: each lane counts 16, S=256
        for (int i = 0; i < N; i++) begin a_v[i] = 8'd16; b_v[i] = 8'd255; end
        launch(1'b0, 8'd255, 1'b1, 16, "sat_mode", 1'b1);
        chk("busy_running", int'(busy), 1);
        wait_idle("sat_mode");
        launch(1'b1, 8'd16, 1'b0, 16, "scaled", 1'b1);
        wait_idle("scaled");

        // A_i=i, B=1: S = 0+1+...+15 = 120
        for (int i = 0; i < N; i++) begin a_v[i] = W'(i); b_v[i] = 8'd1; end
        launch(1'b0, 8'd120, 1'b0, 15, "ramp", 1'b1);
        // a start during RUN (t=5) must be ignored
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ramp");
        rng_c = 8'd119; #1 chk("oc_119", int'(oC), 1);
        rng_c = 8'd120; #1 chk("oc_120", int'(oC), 0);
        chk("hold_valid", int'(result_valid), 1);
        rng_c = '1;

        // B=0 on every lane: nothing ever counts whatever rng_b does
        for (int i = 0; i < N; i++) begin a_v[i] = 8'd255; b_v[i] = 8'd0; end
        rand_b_en = 1'b1;
        launch(1'b0, 8'd0, 1'b0, 255, "b_zero", 1'b1);
        chk("start_clears_valid", int'(result_valid), 0);
        wait_idle("b_zero");
        rand_b_en = 1'b0;
        foreach (a_v[k]) begin
            if (k < 3) begin
                rng_c = W'(k * 127); #1 chk("oc_zero_result", int'(oC), 0);
            end
        end
        chk("b_zero_valid_hold", int'(result_valid), 1);

        // reset at t=100 aborts the window without done
        for (int i = 0; i < N; i++) begin a_v[i] = W'(i); b_v[i] = 8'd1; end
        launch(1'b0, 8'd0, 1'b0, 15, "abort", 1'b0);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(result_valid), 0);
        chk("abort_result", int'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        launch(1'b0, 8'd120, 1'b0, 15, "after_abort", 1'b1);
        wait_idle("after_abort");

        // max A = 10, others 5: S = 10 + 15*5 = 85
        for (int i = 0; i < N; i++) begin a_v[i] = 8'd5; b_v[i] = 8'd255; end
        a_v[3] = 8'd10;
        launch(1'b0, 8'd85, 1'b0, 10, "amax10", 1'b1);
        wait_idle("amax10");
        for (int i = 0; i < N; i++) a_v[i] = 8'd0;
        launch(1'b1, 8'd0, 1'b0, 0, "a_zero", 1'b1);
        wait_idle("a_zero");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
